// File: rtl/dmem_pkg.sv
// Constants and port types shared between the data-memory responder and the core.
package dmem_pkg;
  localparam int WORD_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int BYTE_W    = 8;

  typedef logic [NUM_LANES-1:0][BYTE_W-1:0] word_t;

  typedef struct packed {
    logic [NUM_LANES-1:0] be;
    word_t                data;
  } wr_lane_t;
endpackage

// File: rtl/dmem_ram_core.sv
// Word storage: one lane-masked write port, one synchronous read port (read-before-write).
module dmem_ram_core
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  wr_lane_t         wr,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output word_t            rd_q
);
  word_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int l = 0; l < NUM_LANES; l++)
        if (wr.be[l]) mem[wr_idx][l] <= wr.data[l];
    if (rd_en) rd_q <= mem[rd_idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: range check, write-first bypass and sticky fault capture around dmem_ram_core.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_rd_req_i,
  input  logic [WORD_W-1:0]    mem_rd_addr_i,
  output logic [WORD_W-1:0]    mem_rd_data_o,
  input  logic                 mem_wd_req_i,
  input  logic [WORD_W-1:0]    mem_wd_addr_i,
  input  logic [WORD_W-1:0]    mem_wd_data_i,
  input  logic [NUM_LANES-1:0] mem_wd_sel_i,
  output logic                 err_o,
  output logic [WORD_W-1:0]    err_addr_o,
  input  logic                 err_clr_i
);
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

  logic [31:0]      rd_off, wr_off;
  logic             rd_in, wr_in, rd_act, wr_act, rd_oor, wr_oor;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  wr_lane_t         wr;
  word_t            rd_q, byp_data_q;
  logic [NUM_LANES-1:0] byp_sel_q;
  logic             zero_q;

  // Offset compare catches both wrap below BASE_ADDR and overrun past the top.
  assign rd_off = mem_rd_addr_i - BASE_ADDR;
  assign wr_off = mem_wd_addr_i - BASE_ADDR;
  assign rd_in  = (mem_rd_addr_i >= BASE_ADDR) && (rd_off < SPAN);
  assign wr_in  = (mem_wd_addr_i >= BASE_ADDR) && (wr_off < SPAN);
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_idx = wr_off[IDX_W+1:2];

  assign rd_act = !rst && mem_rd_req_i;
  assign wr_act = !rst && mem_wd_req_i && (mem_wd_sel_i != '0);
  assign rd_oor = rd_act && !rd_in;
  assign wr_oor = wr_act && !wr_in;

  assign wr = '{be: mem_wd_sel_i, data: mem_wd_data_i};

  dmem_ram_core #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk    (clk),
    .wr_en  (wr_act && wr_in),
    .wr_idx (wr_idx),
    .wr     (wr),
    .rd_en  (rd_act && rd_in),
    .rd_idx (rd_idx),
    .rd_q   (rd_q)
  );

  // Read-side select state only moves on a completed read, so output holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b1;
      byp_sel_q  <= '0;
      byp_data_q <= '0;
    end else if (rd_act) begin
      zero_q     <= !rd_in;
      byp_sel_q  <= (rd_in && wr_act && wr_in && rd_idx == wr_idx) ? mem_wd_sel_i : '0;
      byp_data_q <= mem_wd_data_i;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign mem_rd_data_o[l*BYTE_W +: BYTE_W] =
      zero_q       ? '0            :
      byp_sel_q[l] ? byp_data_q[l] : rd_q[l];
  end

  // A new fault wins over a clear; write address wins over read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if ((wr_oor || rd_oor) && (!err_o || err_clr_i)) begin
      err_o      <= 1'b1;
      err_addr_o <= wr_oor ? mem_wd_addr_i : mem_rd_addr_i;
    end else if (err_clr_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, SHALL set the number of 32-bit storage words (power of two, 16..65536).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0 (DEPTH_WORDS*4-aligned).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 mem_rd_req_i  input  1  SHALL be the read request from the core data port.
REQ-006 mem_rd_addr_i  input  32  SHALL be the read byte address.
REQ-007 mem_rd_data_o  output  32  SHALL be the registered read data.
REQ-008 mem_wd_req_i  input  1  SHALL be the write request.
REQ-009 mem_wd_addr_i  input  32  SHALL be the write byte address.
REQ-010 mem_wd_data_i  input  32  SHALL be the write data, byte lane i = bits [8i+7:8i].
REQ-011 mem_wd_sel_i  input  4  SHALL be the byte-lane write enables, bit i enables lane i.
REQ-012 err_o  output  1  SHALL be the sticky out-of-range access flag.
REQ-013 err_addr_o  output  32  SHALL be the byte address of the captured faulting access.
REQ-014 err_clr_i  input  1  SHALL clear err_o and err_addr_o.

Function
REQ-015 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; access in range iff addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-016 Read latency SHALL be one cycle: request sampled at edge k, data on mem_rd_data_o from edge k until the next read completes.
REQ-017 With mem_rd_req_i low, mem_rd_data_o SHALL hold its last value.
REQ-018 Write SHALL update only the lanes enabled in mem_wd_sel_i at the sampling edge; other lanes unchanged.
REQ-019 mem_wd_req_i high with mem_wd_sel_i = 4'b0000 SHALL change no storage and raise no error.
REQ-020 Read and write to the same word in the same cycle SHALL return the merged post-write word (write-first bypass).
REQ-021 Read and write to different words in the same cycle SHALL both complete independently.
REQ-022 Out-of-range write SHALL be dropped; out-of-range read SHALL load 32'h0 into mem_rd_data_o.
REQ-023 Out-of-range access with err_o low SHALL set err_o and capture its byte address in err_addr_o.
REQ-024 Further errors while err_o is high SHALL not change err_addr_o (first fault kept).
REQ-025 Simultaneous out-of-range read and write with err_o low SHALL capture the write address.
REQ-026 err_clr_i with no new error SHALL clear err_o and err_addr_o to 0 at the next edge.
REQ-027 err_clr_i concurrent with a new error SHALL leave err_o set and capture the new address.
REQ-028 Address arithmetic SHALL be 32-bit unsigned; wrap below BASE_ADDR SHALL be treated as out of range.

Reset
REQ-029 While rst is high, mem_rd_data_o, err_o and err_addr_o SHALL be 0 at the next edge.
REQ-030 Requests sampled while rst is high SHALL be ignored, including writes (no storage change).
REQ-031 Storage contents SHALL not be reset and SHALL be preserved across a mid-operation reset.

Structure
REQ-032 Shared package SHALL hold the word-width, lane-count and byte-width constants shared with the core.
REQ-033 One sub-module dmem_ram_core SHALL hold the storage array with one write port (per-lane enable) and one synchronous read port; bypass, range check and error logic SHALL live in dmem_responder.

Verification
REQ-034 Write 32'hDEADBEEF sel 4'hF to 0x10, read 0x10 next cycle -> mem_rd_data_o = 32'hDEADBEEF one edge after the read request.
REQ-035 Then write 32'h0000_00AA sel 4'b0001 to 0x12, read 0x10 -> 32'hDEADBEAA.
REQ-036 Same-cycle write 32'h12345678 sel 4'hF and read at 0x20 -> read returns 32'h12345678.
REQ-037 Read 0x0000_4000 (DEPTH 4096) -> data 0, err_o = 1, err_addr_o = 0x4000; then write 0x5000 -> err_addr_o stays 0x4000; err_clr_i with read 0x6000 -> err_addr_o = 0x6000.
REQ-038 Write 32'hCAFEF00D to 0x30, pulse rst with write 32'h0 to 0x30 in the same cycle -> outputs 0, later read 0x30 = 32'hCAFEF00D.
